lsu_bus_master: RTL and testbench
=================================

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter DEV_BASE, default 32'hFFFFF000; addresses >= DEV_BASE are device space.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load (else sign-extend)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  request rejected, no bus access
- bus_addr  out  32  word-aligned bus address
- bus_we  out  1  bus write strobe
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data, combinational from bus_addr, same cycle

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, MERGE, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a clk edge with req_valid && req_ready, latching all req_* fields.
REQ-005 Error SHALL be detected at acceptance: size 11; half with addr[0]=1; word with addr[1:0]!=0; byte/half store with addr >= DEV_BASE (no read-modify-write on devices).
REQ-006 Error request: IDLE -> RESP; no bus cycle; resp_err=1, resp_rdata=0.
REQ-007 Non-error request: IDLE -> ACCESS; bus_addr = {addr[31:2],2'b00}.
REQ-008 ACCESS, load: bus_we=0; bus_rdata captured at edge; -> RESP.
REQ-009 ACCESS, word store: bus_we=1, bus_wdata=req_wdata; -> RESP.
REQ-010 ACCESS, byte/half store: bus_we=0, bus_rdata captured; -> MERGE.
REQ-011 MERGE: bus_we=1, bus_wdata = captured word with lane replaced: byte lane addr[1:0] <- wdata[7:0]; half lane addr[1] <- wdata[15:0]; other bytes unchanged; -> RESP.
REQ-012 Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]; word = rdata; extend to 32 bits by bit 7/15 unless req_unsigned.
REQ-013 RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err valid; -> IDLE.
REQ-014 Latency (accept edge = cycle N): load and word store resp_valid in N+2; sub-word store bus read N+1, write N+2, resp_valid N+3; error resp_valid N+1.
REQ-015 Outside ACCESS/MERGE, bus_addr, bus_we, bus_wdata SHALL be 0; bus_we SHALL never be 1 for more than one consecutive cycle per request.
REQ-016 resp_valid, resp_err, resp_rdata SHALL be 0 in every cycle other than RESP.
REQ-017 req_* changes after acceptance SHALL have no effect on the in-flight request.
REQ-018 Back-to-back: a request valid on the edge that leaves RESP is not accepted; it is accepted the following edge (IDLE).

Reset
REQ-019 rst_n low SHALL immediately force state IDLE, all outputs 0 except req_ready=1, and clear all latched fields.
REQ-020 Reset asserted mid-request (ACCESS/MERGE) SHALL abort it: bus_we drops to 0 without clock; no resp_valid for the aborted request.

Verification
REQ-021 Word store addr 0x100, wdata 0xDEADBEEF then word load 0x100 -> one write cycle with bus_addr 0x100; load resp_rdata 0xDEADBEEF at N+2.
REQ-022 Memory 0x200 = 0x11223344; byte store 0xAB to 0x201 -> read cycle, then write 0x1122AB44 at N+2; resp_valid N+3.
REQ-023 Memory 0x300 = 0x80F07F01; loads: byte 0x302 signed -> 0xFFFFFFF0; byte 0x302 unsigned -> 0x000000F0; half 0x302 signed -> 0xFFFF80F0; byte 0x301 signed -> 0x0000007F.
REQ-024 Errors: half load 0x101, word store 0x102, size 11, byte store 0xFFFFF060 -> resp_err=1 at N+1, bus_we never 1, bus_addr stays 0.
REQ-025 rst_n pulsed low during MERGE of a half store -> bus_we 0 immediately, no resp_valid, req_ready=1 after release; next load completes normally.
REQ-026 req_valid held high continuously with alternating loads/stores -> one acceptance per transaction, req_ready only in IDLE, resp_valid never on consecutive cycles.

Source files
------------

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns CPU byte/half/word requests into word-aligned bus cycles,
// doing read-modify-write for sub-word stores and sign/zero extension for loads.
module lsu_bus_master #(
    parameter logic [31:0] DEV_BASE = 32'hFFFFF000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Sub-word stores to device space are rejected: devices cannot tolerate the read half of an RMW.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_err = 1'b0;
        case (req_size)
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_we && req_size != SZ_WORD && req_addr >= DEV_BASE)
            req_err = 1'b1;
    end

    always_comb begin
        sel_b      = bus_rdata[{off_q, 3'b000} +: 8];
        sel_h      = bus_rdata[{off_q[1], 4'b0000} +: 16];
        load_data  = bus_rdata;
        merge_data = bus_rdata;
        case (size_q)
            SZ_BYTE: begin
                load_data = uns_q ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
                merge_data[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_data = uns_q ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
                merge_data[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // All outputs are registered and set on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            bus_addr   <= 32'h0;
            bus_we     <= 1'b0;
            bus_wdata  <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_we    <= req_we && req_size == SZ_WORD;
                            bus_wdata <= (req_we && req_size == SZ_WORD) ? req_wdata : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q && size_q != SZ_WORD) begin
                        state     <= MERGE;
                        bus_we    <= 1'b1;
                        bus_wdata <= merge_data;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'h0 : load_data;
                        bus_addr   <= 32'h0;
                        bus_we     <= 1'b0;
                        bus_wdata  <= 32'h0;
                    end
                end
                MERGE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    bus_addr   <= 32'h0;
                    bus_we     <= 1'b0;
                    bus_wdata  <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: table of directed transactions against a word
// memory model, plus hand-written reset-abort and back-to-back sequences.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    lsu_bus_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    // Word memory model; the bus reads combinationally and writes on the rising edge.
    logic [31:0] mem [0:1023];
    assign bus_rdata = mem[bus_addr[11:2]];
    always @(posedge clk) if (bus_we) mem[bus_addr[11:2]] <= bus_wdata;

    // Bus/response monitor, sampled on the falling edge.
    int          n_writes = 0;
    int          n_bus    = 0;
    int          n_resp   = 0;
    int          viol     = 0;
    logic [31:0] last_wdata = 32'h0;
    logic        prev_we = 1'b0;
    logic        prev_rv = 1'b0;
    always @(negedge clk) begin
        if (bus_we) begin
            n_writes++;
            last_wdata = bus_wdata;
            if (prev_we) viol++;
        end
        if (bus_addr != 32'h0) n_bus++;
        if (resp_valid) begin
            n_resp++;
            if (prev_rv) viol++;
        end
        if (!resp_valid && (resp_err || resp_rdata != 32'h0)) viol++;
        if (req_ready && (bus_we || bus_addr != 32'h0 || resp_valid)) viol++;
        prev_we = bus_we;
        prev_rv = resp_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nbus;
        int          nw;
        logic [31:0] wd;
    } vec_t;

    task automatic do_txn(input vec_t v, input int idx);
        int lat;
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("v%0d_ready", idx), {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        n_writes     = 0;
        n_bus        = 0;
        req_valid    = 1'b0;
        req_we       = ~v.we;
        req_size     = ~v.size;
        req_unsigned = ~v.uns;
        req_addr     = 32'h0000_0554;
        req_wdata    = 32'h5A5A_5A5A;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
        check($sformatf("v%0d_err", idx), {31'h0, resp_err}, {31'h0, v.err});
        @(posedge clk);
        #1;
        check($sformatf("v%0d_resp_pulse", idx), {31'h0, resp_valid}, 32'h0);
        check($sformatf("v%0d_bus_cycles", idx), n_bus, v.nbus);
        check($sformatf("v%0d_writes", idx), n_writes, v.nw);
        if (v.nw > 0) check($sformatf("v%0d_wdata", idx), last_wdata, v.wd);
    endtask

    vec_t vecs[$];

    initial begin
        int accepts;
        int resp0;
        int dbl_ready;
        logic prev_ready;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h200 >> 2] = 32'h1122_3344;
        mem[32'h300 >> 2] = 32'h80F0_7F01;

        //          we    size   uns   addr           wdata          err   rdata          lat nbus nw wd
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,         2, 1, 1, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_56AB, 1'b0, 32'h0,         3, 2, 1, 32'h1122_AB44});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 32'h1122_AB44, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0302, 32'h0,         1'b0, 32'hFFFF_FFF0, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0302, 32'h0,         1'b0, 32'h0000_00F0, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0302, 32'h0,         1'b0, 32'hFFFF_80F0, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0301, 32'h0,         1'b0, 32'h0000_007F, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0300, 32'h0,         1'b0, 32'h0000_7F01, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hFFFF_CAFE, 1'b0, 32'h0,         3, 2, 1, 32'hCAFE_AB44});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 32'hCAFE_AB44, 2, 1, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,         1'b1, 32'h0,         1, 0, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1111_1111, 1'b1, 32'h0,         1, 0, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         1, 0, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'hFFFF_F060, 32'h0000_0077, 1'b1, 32'h0,         1, 0, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0303, 32'h0000_005A, 1'b0, 32'h0,         3, 2, 1, 32'h5AF0_7F01});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0303, 32'h0,         1'b0, 32'h0000_005A, 2, 1, 0, 32'h0});

        // Reset state while rst_n is held low.
        #12;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_bus_we", {31'h0, bus_we}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_txn(vecs[i], i);

        // Reset pulsed during MERGE of a half store: write must never happen.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h0000_0300; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp0 = n_resp;
        @(posedge clk);
        #1;
        check("abort_in_merge_we", {31'h0, bus_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_we_drop", {31'h0, bus_we}, 32'h0);
        check("abort_bus_addr", bus_addr, 32'h0);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_no_resp", n_resp - resp0, 0);
        check("abort_mem_intact", mem[32'h300 >> 2], 32'h5AF0_7F01);
        do_txn('{1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 32'h5AF0_7F01, 2, 1, 0, 32'h0}, 100);

        // req_valid held high with alternating word stores and loads.
        @(negedge clk);
        check("b2b_start_idle", {31'h0, req_ready}, 32'h1);
        accepts = 0;
        dbl_ready = 0;
        prev_ready = 1'b0;
        resp0 = n_resp;
        req_valid = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0000_0400;
        for (int c = 0; c < 30; c++) begin
            if (req_ready) begin
                if (prev_ready) dbl_ready++;
                req_we    = (accepts % 2) == 0;
                req_wdata = 32'hA000_0000 + accepts;
                accepts++;
            end
            prev_ready = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_accepts", accepts, 10);
        check("b2b_responses", n_resp - resp0, 10);
        check("b2b_ready_single", dbl_ready, 0);
        check("b2b_last_store", mem[32'h400 >> 2], 32'hA000_0008);

        check("monitor_violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
